// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR execute sequencer: op codes, CSR
// addresses, register-file indices, trap causes and FSM states.
package csr_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CSRRW = 3'd1,
    OP_CSRRS = 3'd2,
    OP_CSRRC = 3'd3,
    OP_ECALL = 3'd4,
    OP_MRET  = 3'd5
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [2:0] MSTATUS_IDX = 3'd0;
  localparam logic [2:0] MTVEC_IDX   = 3'd1;
  localparam logic [2:0] MEPC_IDX    = 3'd2;
  localparam logic [2:0] MCAUSE_IDX  = 3'd3;

  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } csr_state_e;

endpackage

// File: rtl/csr_addr_decode.sv
// Maps a 12-bit CSR number onto the 4-entry register file index; hit_o is
// low for any CSR the file does not implement.
module csr_addr_decode
  import csr_pkg::*;
(
  input  logic [11:0] addr_i,
  output logic        hit_o,
  output logic [2:0]  idx_o
);

  always_comb begin
    hit_o = 1'b1;
    idx_o = MSTATUS_IDX;
    unique case (addr_i)
      ADDR_MSTATUS: idx_o = MSTATUS_IDX;
      ADDR_MTVEC:   idx_o = MTVEC_IDX;
      ADDR_MEPC:    idx_o = MEPC_IDX;
      ADDR_MCAUSE:  idx_o = MCAUSE_IDX;
      default: begin
        hit_o = 1'b0;
        idx_o = MSTATUS_IDX;
      end
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// Execute-stage sequencer for Zicsr/ECALL/MRET: reads the CSR file, then
// writes it (or raises a trap) one cycle later, then holds the result.
module csr_exec_unit
  import csr_pkg::*;
#(
  parameter int         XLEN        = 64,
  parameter logic [3:0] ECALL_CAUSE = CAUSE_ECALL_M,
  parameter logic [3:0] ILLEG_CAUSE = CAUSE_ILLEGAL
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [11:0]     in_csr_addr,
  input  logic [XLEN-1:0] in_src,
  input  logic            in_src_zero,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_wen,
  output logic [2:0]      csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            exc,
  output logic [XLEN-1:0] exc_epc,
  output logic [3:0]      exc_no
);

  csr_state_e state_q, state_d;
  csr_op_e    op_q;
  logic            hit_q, srcZero_q, redirect_q;
  logic [2:0]      idx_q;
  logic [4:0]      rd_q, outRd_q;
  logic [XLEN-1:0] src_q, pc_q, old_q, outRdata_q, target_q;

  logic            decHit;
  logic [2:0]      decIdx;
  logic            isCsrOp, isMret, isTrap;
  logic [XLEN-1:0] writeData;
  logic [4:0]      resRd;
  logic [XLEN-1:0] resRdata, resTarget;
  logic            resRedirect;

  csr_addr_decode u_decode (
    .addr_i (in_csr_addr),
    .hit_o  (decHit),
    .idx_o  (decIdx)
  );

  // Anything that is neither a mapped CSR op nor MRET traps (ECALL or illegal).
  assign isCsrOp = hit_q && (op_q == OP_CSRRW || op_q == OP_CSRRS || op_q == OP_CSRRC);
  assign isMret  = (op_q == OP_MRET);
  assign isTrap  = !isCsrOp && !isMret;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    writeData = src_q;
    unique case (op_q)
      OP_CSRRS: writeData = old_q | src_q;
      OP_CSRRC: writeData = old_q & ~src_q;
      default:  writeData = src_q;
    endcase
  end

  // Strobes are masked by reset so an op aborted in WRITE leaves no side effect.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    csr_raddr = '0;
    csr_wen   = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    exc       = 1'b0;
    exc_epc   = '0;
    exc_no    = '0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_READ;
      end
      S_READ: begin
        csr_raddr = isCsrOp ? idx_q : (isMret ? MEPC_IDX : MTVEC_IDX);
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (isCsrOp) begin
          csr_waddr = idx_q;
          csr_wdata = writeData;
          csr_wen   = !reset && (op_q == OP_CSRRW || !srcZero_q);
        end else if (isTrap) begin
          exc     = !reset;
          exc_epc = pc_q;
          exc_no  = (op_q == OP_ECALL) ? ECALL_CAUSE : ILLEG_CAUSE;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    resRd       = '0;
    resRdata    = '0;
    resRedirect = 1'b0;
    resTarget   = '0;
    if (isCsrOp) begin
      resRd    = rd_q;
      resRdata = old_q;
    end else if (isMret) begin
      resRdata    = old_q;
      resRedirect = 1'b1;
      resTarget   = old_q;
    end else begin
      resRedirect = 1'b1;
      resTarget   = {old_q[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q       <= OP_NONE;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      src_q      <= '0;
      srcZero_q  <= 1'b0;
      pc_q       <= '0;
      rd_q       <= '0;
      old_q      <= '0;
      outRd_q    <= '0;
      outRdata_q <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        op_q      <= csr_op_e'(in_op);
        hit_q     <= decHit;
        idx_q     <= decIdx;
        src_q     <= in_src;
        srcZero_q <= in_src_zero;
        pc_q      <= in_pc;
        rd_q      <= in_rd;
      end
      if (state_q == S_READ) old_q <= csr_rdata;
      if (state_q == S_WRITE) begin
        outRd_q    <= resRd;
        outRdata_q <= resRdata;
        redirect_q <= resRedirect;
        target_q   <= resTarget;
      end
    end
  end

  assign out_rd       = outRd_q;
  assign out_rdata    = outRdata_q;
  assign out_target   = target_q;
  assign out_redirect = redirect_q && (state_q == S_RESP);

endmodule
